// File: rtl/imem_loadable.sv
// Loadable instruction memory: power-up clear sweep, registered fetch port with
// fault reporting, and a byte-stream loader that packs bytes into words.
module imem_loadable #(
  parameter int          DEPTH_WORDS = 256,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter logic [31:0] FAULT_WORD  = 32'h00000013
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic        fetch_req,
  output logic [31:0] RD,
  output logic        rd_valid,
  output logic        fault,
  output logic        ready,
  input  logic        ld_start,
  input  logic [31:0] ld_base,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_done
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   asm_merge;
  logic [31:0]   rd_q;
  logic          rd_valid_q, rd_valid_d;
  logic          fault_q, fault_d;
  logic          ld_done_q, ld_done_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          fetch_acc;
  logic          fetch_bad;
  logic [AW-1:0] fetch_idx;
  logic          byte_acc;
  logic          word_wr;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  logic          unused_ld_base;
  assign unused_ld_base = ^{ld_base[1:0], ld_base[31:2+AW]};

  assign fetch_idx = A[2 +: AW];
  assign fetch_bad = (A[1:0] != 2'b00) || (A[31:2+AW] != '0);

  // Each lane takes the incoming byte when the byte counter points at it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = BIG_ENDIAN ? 2'(3 - gi) : 2'(gi);
    assign asm_merge[8*gi +: 8] = (bcnt_q == LANE) ? ld_byte : asm_q[8*gi +: 8];
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (wptr_q == '1) state_d = S_IDLE;
      S_IDLE:  if (ld_start) state_d = S_LOAD;
      S_LOAD:  if (ld_valid && ld_last) state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    ld_ready  = (state_q == S_LOAD);
    fetch_acc = ready && fetch_req;
    byte_acc  = ld_ready && ld_valid;
    word_wr   = byte_acc && ((bcnt_q == 2'd3) || ld_last);
    // Gating with Reset keeps an aborted session from committing its word.
    mem_we    = !Reset && ((state_q == S_CLEAR) || word_wr);
    mem_wdata = (state_q == S_CLEAR) ? 32'h0 : asm_merge;
  end

  always_comb begin
    wptr_d     = wptr_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    rd_valid_d = fetch_acc;
    fault_d    = fetch_acc && fetch_bad;
    ld_done_d  = byte_acc && ld_last;
    case (state_q)
      S_CLEAR: wptr_d = wptr_q + 1'b1;
      S_IDLE: begin
        if (ld_start) begin
          wptr_d = ld_base[2 +: AW];
          bcnt_d = 2'd0;
          asm_d  = 32'h0;
        end
      end
      S_LOAD: begin
        if (word_wr) begin
          wptr_d = wptr_q + 1'b1;
          bcnt_d = 2'd0;
          asm_d  = 32'h0;
        end else if (byte_acc) begin
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = asm_merge;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      wptr_q     <= '0;
      bcnt_q     <= 2'd0;
      asm_q      <= 32'h0;
      rd_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      ld_done_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      rd_valid_q <= rd_valid_d;
      fault_q    <= fault_d;
      ld_done_q  <= ld_done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[wptr_q] <= mem_wdata;
  end

  // Registered read port; holds its value between accepted fetches.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rd_q <= 32'h0;
    end else if (fetch_acc) begin
      rd_q <= fetch_bad ? FAULT_WORD : mem[fetch_idx];
    end
  end

  assign RD       = rd_q;
  assign rd_valid = rd_valid_q;
  assign fault    = fault_q;
  assign ld_done  = ld_done_q;

endmodule
